// File: rtl/seq_detector_param_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg : shared defaults and helpers for the seq_detector_param block
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int COUNT_W_DEF = 8;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Low-order mask with 'len' ones; selects the active part of the pattern.
  function automatic logic [MAX_LEN_DEF-1:0] mask_bits(input int len);
    logic [MAX_LEN_DEF-1:0] m;
    for (int i = 0; i < MAX_LEN_DEF; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : W-bit up counter with synchronous clear, holds at all-ones
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param : runtime-programmable serial pattern detector
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [COUNT_W-1:0] match_count
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic               hit;

  assign len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
  assign hist_nxt    = {hist[MAX_LEN-2:0], in};
  assign fill_inc    = {1'b0, fill} + (LEN_W + 1)'(1);

  // The package helper is sized for the default length; other sizes build the mask locally.
  if (MAX_LEN == MAX_LEN_DEF) begin : g_mask_pkg
    assign mask = mask_bits(int'(len_q));
  end else begin : g_mask_loop
    always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mask[i] = (i < int'(len_q));
      end
    end
  end

  assign hit = in_valid && !cfg_load && (len_q != '0)
             && (fill_inc >= {1'b0, len_q})
             && ((hist_nxt & mask) == (pattern_q & mask));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= len_clamped;
      overlap_q <= cfg_overlap;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
    end else begin
      out <= hit;
      if (in_valid) begin
        hist <= hist_nxt;
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        if (hit && !overlap_q) begin
          fill <= '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .W (COUNT_W)
  ) u_match_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cfg_load),
    .inc     (hit),
    .cnt     (match_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param : directed self-checking bench for seq_detector_param
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int COUNT_W = 4;
  localparam int LEN_W   = 4;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               in = 1'b0;
  logic               out;
  logic [COUNT_W-1:0] match_count;

  int passed = 0;
  int total  = 0;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .COUNT_W (COUNT_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in          (in),
    .out         (out),
    .match_count (match_count)
  );

  always #5 clock = ~clock;

  // One sampling edge; outputs are observed 1 ns after it.
  task automatic drive(input logic v, input logic b);
    @(negedge clock);
    in_valid = v;
    in       = b;
    @(posedge clock);
    #1;
  endtask

  // Load with in_valid=1/in=1 so a sampled bit would corrupt the history.
  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    @(negedge clock);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    in_valid    = 1'b1;
    in          = 1'b1;
    @(posedge clock);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out); else passed++;
    total++;
    if (match_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", match_count); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_pattern_110();
    logic [4:0] bits = 5'b01101;
    logic [4:0] exp  = 5'b00010;
    load(8'b110, 4'd3, 1'b1);
    total++;
    if (match_count !== 4'd0) $display("FAIL p110_load_count: got %0d want 0", match_count); else passed++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[4-i]);
      total++;
      if (out !== exp[4-i]) $display("FAIL p110_out[%0d]: got %b want %b", i, out, exp[4-i]); else passed++;
    end
    total++;
    if (match_count !== 4'd1) $display("FAIL p110_count: got %0d want 1", match_count); else passed++;
  endtask

  task automatic test_overlap(input logic ov);
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp;
    logic [3:0] exp_cnt;
    exp     = ov ? 5'b00101 : 5'b00100;
    exp_cnt = ov ? 4'd2 : 4'd1;
    load(8'b101, 4'd3, ov);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[4-i]);
      total++;
      if (out !== exp[4-i]) $display("FAIL ovl%0b_out[%0d]: got %b want %b", ov, i, out, exp[4-i]); else passed++;
    end
    total++;
    if (match_count !== exp_cnt) $display("FAIL ovl%0b_count: got %0d want %0d", ov, match_count, exp_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1);
      total++;
      if (out !== 1'b1) $display("FAIL b2b_out[%0d]: got %b want 1", i, out); else passed++;
      if (i == 14 || i == 19) begin
        total++;
        if (match_count !== 4'd15) $display("FAIL b2b_sat[%0d]: got %0d want 15", i, match_count); else passed++;
      end
    end
    drive(1'b1, 1'b0);
    total++;
    if (out !== 1'b0) $display("FAIL b2b_zero_out: got %b want 0", out); else passed++;
  endtask

  task automatic test_idle_gap();
    logic [6:0] vld = 7'b1100011;
    logic [6:0] exp = 7'b0000001;
    load(8'b1111, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(vld[6-i], 1'b1);
      total++;
      if (out !== exp[6-i]) $display("FAIL idle_out[%0d]: got %b want %b", i, out, exp[6-i]); else passed++;
    end
    total++;
    if (match_count !== 4'd1) $display("FAIL idle_count: got %0d want 1", match_count); else passed++;
  endtask

  task automatic test_reload_flush();
    logic [2:0] bits = 3'b110;
    logic [2:0] exp  = 3'b001;
    load(8'b110, 4'd3, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    load(8'b110, 4'd3, 1'b1);
    drive(1'b1, 1'b0);
    total++;
    if (out !== 1'b0) $display("FAIL flush_out: got %b want 0", out); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bits[2-i]);
      total++;
      if (out !== exp[2-i]) $display("FAIL flush_out[%0d]: got %b want %b", i, out, exp[2-i]); else passed++;
    end
    total++;
    if (match_count !== 4'd1) $display("FAIL flush_count: got %0d want 1", match_count); else passed++;
  endtask

  task automatic test_len_limits();
    logic [7:0] bits = 8'hA5;
    load(8'b110, 4'd0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    total++;
    if (out !== 1'b0 || match_count !== 4'd0)
      $display("FAIL len0: got out=%b count=%0d want out=0 count=0", out, match_count);
    else passed++;
    // Length 15 is clamped to 8, so the full 8-bit pattern must match.
    load(8'hA5, 4'd15, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, bits[7-i]);
      total++;
      if (out !== (i == 7)) $display("FAIL clamp_out[%0d]: got %b want %b", i, out, (i == 7)); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    load(8'b110, 4'd3, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (out !== 1'b0 || match_count !== 4'd0)
      $display("FAIL midrst_async: got out=%b count=%0d want out=0 count=0", out, match_count);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    total++;
    if (out !== 1'b0) $display("FAIL midrst_cfg_cleared: got %b want 0", out); else passed++;
    load(8'b110, 4'd3, 1'b1);
    drive(1'b1, 1'b0);
    total++;
    if (out !== 1'b0 || match_count !== 4'd0)
      $display("FAIL midrst_no_match: got out=%b count=%0d want out=0 count=0", out, match_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pattern_110();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_back_to_back();
    test_idle_gap();
    test_reload_flush();
    test_len_limits();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
